// File: rtl/regfile_dump.sv
// Debug read-out engine: walks the register file in index order and streams {index, data} beats.
// Optional trailing checksum beat enabled by defining REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump #(
  parameter int NREGS = 32,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rsel,
  input  logic [DW-1:0] rdat,
  input  logic          wen,
  input  logic [AW-1:0] wsel,
  input  logic [DW-1:0] wdat,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   out_idx,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_SEND = 3'd2,
`ifdef REGFILE_DUMP_CHECKSUM_EN
    S_CSUM = 3'd3,
`endif
    S_DONE = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t        state_r;
  logic [AW-1:0] idx_r;
  logic [DW-1:0] hold_r;
  logic [AW-1:0] out_idx_lo_r;
  logic          snoop_hit_s;
  logic [DW-1:0] rd_val_s;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DW-1:0] csum_r;
  logic          csum_beat_r;
  assign out_idx = {csum_beat_r, out_idx_lo_r};
`else
  assign out_idx = {1'b0, out_idx_lo_r};
`endif

  assign rsel     = idx_r;
  assign out_data = hold_r;

  // Write snoop and read value; register 0 is never bypassed and always reads as zero
  always_comb begin
    snoop_hit_s = 1'b0;
    rd_val_s    = {DW{1'b0}};
    if (idx_r != {AW{1'b0}}) begin
      snoop_hit_s = wen && (wsel == idx_r);
      rd_val_s    = snoop_hit_s ? wdat : rdat;
    end else begin
      snoop_hit_s = 1'b0;
      rd_val_s    = {DW{1'b0}};
    end
  end

  // Dump sequencer with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      idx_r        <= {AW{1'b0}};
      hold_r       <= {DW{1'b0}};
      out_idx_lo_r <= {AW{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_r       <= {DW{1'b0}};
      csum_beat_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          done  <= 1'b0;
          idx_r <= {AW{1'b0}};
          if (start) begin
            state_r <= S_READ;
            busy    <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_r  <= {DW{1'b0}};
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        S_READ: begin
          hold_r       <= rd_val_s;
          out_idx_lo_r <= idx_r;
          out_valid    <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          out_last     <= 1'b0;
`else
          out_last     <= (idx_r == LAST_IDX);
`endif
          state_r      <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_r <= csum_r + hold_r;
`endif
            if (idx_r == LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              // Checksum beat reuses hold so out_data stays a plain register
              hold_r       <= csum_r + hold_r;
              out_idx_lo_r <= {AW{1'b0}};
              csum_beat_r  <= 1'b1;
              out_last     <= 1'b1;
              state_r      <= S_CSUM;
`else
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state_r   <= S_DONE;
`endif
            end else begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              idx_r     <= idx_r + {{(AW-1){1'b0}}, 1'b1};
              state_r   <= S_READ;
            end
          end else if (snoop_hit_s) begin
            hold_r <= wdat;
          end else begin
            hold_r <= hold_r;
          end
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        S_CSUM: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            csum_beat_r <= 1'b0;
            done        <= 1'b1;
            state_r     <= S_DONE;
          end else begin
            out_valid <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          done         <= 1'b0;
          busy         <= 1'b0;
          idx_r        <= {AW{1'b0}};
          out_idx_lo_r <= {AW{1'b0}};
          state_r      <= S_IDLE;
        end
        default: begin
          state_r   <= S_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          idx_r     <= {AW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine that sits on the read side of the CPU register file. On a start pulse it walks every architectural register in index order, reads each one through a combinational read port, and streams `{index, data}` beats out over a valid/ready handshake to the debug/trace path. It snoops the register-file write port so that a streamed value always reflects the latest write to that register.

## Interface
- `NREGS`, 32, number of registers to walk (power of two, ≥2)
- `DW`, 32, register data width
- `AW`, 5, register index width, equal to log2(NREGS)

- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a dump; ignored unless IDLE
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last beat is accepted
- `rsel`  out  AW  register-file read select
- `rdat`  in  DW  register-file read data, combinational from `rsel`; index 0 reads 0
- `wen`  in  1  snooped register-file write enable
- `wsel`  in  AW  snooped write select
- `wdat`  in  DW  snooped write data
- `out_valid`  out  1  beat valid
- `out_ready`  in  1  downstream accept
- `out_idx`  out  AW+1  beat index: register index, or NREGS for the checksum beat
- `out_data`  out  DW  beat payload
- `out_last`  out  1  marks the final beat of a dump

## Operation
- FSM states: IDLE, READ, SEND, CSUM (only with the macro), DONE.
- IDLE: `idx`=0. When `start`=1, go to READ.
- READ: `rsel`=`idx`. On the edge, `hold` is loaded with `rdat` and the FSM goes to SEND.
  - If `wen`=1, `wsel`=`idx` and `idx`≠0 in this cycle, `hold` is loaded with `wdat` instead of `rdat` (write-bypass).
- SEND: `out_valid`=1, `out_idx`=`idx`, `out_data`=`hold`.
  - Snoop: if `wen`=1, `wsel`=`idx` and `idx`≠0, then `hold` is loaded with `wdat`. This is the only case where `out_data` may change while `out_valid`=1 and the beat is unaccepted.
  - If `out_valid`=1 and `out_ready`=1 and `idx`=NREGS−1, go to CSUM if the macro is defined, else to DONE.
  - If `out_valid`=1 and `out_ready`=1 and `idx`<NREGS−1, increment `idx` and go to READ.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `rsel` is `idx` in all states; it is 0 in IDLE.
- `start` asserted in any non-IDLE state is dropped, not queued.
- Register 0 is streamed as 0; the snoop never applies to index 0.
- `out_last`=1 only on the final beat: register NREGS−1 without the macro, the CSUM beat with it.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_idx`=0, `out_data`=0, `rsel`=0, `hold`=0, `idx`=0, `csum`=0, state IDLE.
- Reset asserted mid-dump aborts the dump. On the next edge the block is IDLE with no `done` pulse.
- `start` at edge N gives `out_valid`=1 at edge N+2 for index 0.
- Throughput is one beat per 2 cycles with `out_ready` held at 1.
- Each cycle of `out_ready`=0 in SEND adds one stall cycle. The beat holds, except for a snoop update.
- Full dump with `out_ready`=1 and no macro: beats at N+2, N+4, …, N+2·NREGS. `done` follows one cycle after the last beat; `busy` falls on the cycle after `done`.
- `wen` in the same cycle a beat is accepted updates nothing in `hold`, because `idx` advances. The next READ observes the write.

## Configuration
- `REGFILE_DUMP_CHECKSUM_EN`, defined:
  - `csum` (DW bits) is cleared on `start`.
  - On every accepted register beat, `csum` ← `csum` + `out_data`, wrapping mod 2^DW.
  - After the beat for NREGS−1, the CSUM state emits one extra beat with `out_idx`=NREGS, `out_data`=`csum` and `out_last`=1. The beat obeys the same handshake, then the FSM goes to DONE.
- `REGFILE_DUMP_CHECKSUM_EN`, undefined: no `csum` register and no CSUM state. `out_idx` bit AW is tied to 0.

## Test plan
- Preload r_i=i·0x11111111 for i=1..31, `out_ready`=1, pulse `start` → 32 beats: idx 0 carries 0, idx 5 carries 0x55555555; `out_last` on idx 31; `done` at edge N+65.
- `out_ready` toggles 1/0 every cycle → same 32 beats in order; no beat duplicated or dropped; `out_data` stable while stalled.
- Stall at idx 7 (`out_ready`=0) and write r7←0xDEADBEEF → beat idx 7 is accepted with 0xDEADBEEF. A write r0←0xFFFFFFFF during beat 0 → beat 0 still carries 0.
- `rst` asserted for one cycle during beat idx 12 → next cycle `busy`=0, `out_valid`=0, no `done`. A new `start` restarts from idx 0.
- `start` pulsed again while `busy`=1 → ignored; exactly one dump and one `done` pulse.
- With `REGFILE_DUMP_CHECKSUM_EN`, all registers 0x00000001 except r0 → 33 beats. The last beat has `out_idx`=32, `out_data`=0x0000001F and `out_last`=1; idx 31 has `out_last`=0.
